// File: rtl/uart_pkg.sv
// Shared UART definitions: autobaud FSM encoding and default counter/tolerance widths
// used by the baud detector and the RX/TX blocks.
package uart_pkg;

    localparam int CNT_W_DEF     = 16;
    localparam int TOL_SHIFT_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARMED    = 3'd1,
        ST_LOW      = 3'd2,
        ST_HIGH     = 3'd3,
        ST_CHECK    = 3'd4,
        ST_DONE_OK  = 3'd5,
        ST_DONE_ERR = 3'd6
    } baud_state_e;

endpackage

// File: rtl/uart_baud_detect_if.sv
// Control-side handshake of the autobaud detector: arm request in, ratio and status out.
interface uart_baud_detect_if #(
    parameter int WIDTH = 8
);
    logic             i_start;
    logic [WIDTH-1:0] o_div_ratio;
    logic             o_valid;
    logic             o_err;
    logic             o_busy;

    modport master (output i_start, input o_div_ratio, o_valid, o_err, o_busy);
    modport slave  (input i_start, output o_div_ratio, o_valid, o_err, o_busy);
endinterface

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; reset value selects the
// line's idle level so no false edge is seen coming out of reset.
module uart_sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value; blocking here would collapse the two stages into one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {2{RST_VAL}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];
endmodule

// File: rtl/uart_baud_detect.sv
// Autobaud front end: times the start bit and first data bit of a 0x55 sync character
// and publishes their rounded average, prescaled, as the UART divider ratio.
module uart_baud_detect
    import uart_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int DIV_SHIFT = 0,
    parameter int TOL_SHIFT = TOL_SHIFT_DEF
) (
    input  logic              i_ref_clk,
    input  logic              i_rst,
    input  logic              i_rx_in,
    uart_baud_detect_if.slave ctrl
);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_PRE_SAT = CNT_MAX - CNT_ONE;
    localparam logic [CNT_W:0]   RATIO_MIN   = (CNT_W+1)'(2);
    localparam logic [CNT_W:0]   RATIO_MAX   = (CNT_W+1)'((2**WIDTH) - 1);

    logic rx_s;

    baud_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] n1_q, n1_d;
    logic [CNT_W-1:0] n2_q, n2_d;
    logic             seen_q, seen_d;
    logic [WIDTH-1:0] ratio_q, ratio_d;

    logic [CNT_W:0]   sum_w, sum_p1_w, avg_w, r_w;
    logic [CNT_W-1:0] diff_w, tol_w;
    logic             pass_w;

    uart_sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (i_ref_clk),
        .rst_n (i_rst),
        .d_i   (i_rx_in),
        .q_o   (rx_s)
    );

    // Round-half-up average of the two bit periods, then oversampling prescale.
    always_comb begin
        sum_w    = {1'b0, n1_q} + {1'b0, n2_q};
        sum_p1_w = sum_w + (CNT_W+1)'(1);
        avg_w    = sum_p1_w >> 1;
        r_w      = avg_w >> DIV_SHIFT;
        diff_w   = (n1_q >= n2_q) ? (n1_q - n2_q) : (n2_q - n1_q);
        tol_w    = n1_q >> TOL_SHIFT;
        pass_w   = (diff_w <= tol_w) && (r_w >= RATIO_MIN) && (r_w <= RATIO_MAX);
    end

    always_ff @(posedge i_ref_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            n1_q    <= '0;
            n2_q    <= '0;
            seen_q  <= 1'b0;
            ratio_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n1_q    <= n1_d;
            n2_q    <= n2_d;
            seen_q  <= seen_d;
            ratio_q <= ratio_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        n1_d             = n1_q;
        n2_d             = n2_q;
        seen_d           = seen_q;
        ratio_d          = ratio_q;
        ctrl.o_valid     = 1'b0;
        ctrl.o_err       = 1'b0;
        ctrl.o_busy      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                seen_d = 1'b0;
                if (ctrl.i_start) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                ctrl.o_busy = 1'b1;
                if (rx_s) begin
                    seen_d = 1'b1;
                end else if (seen_q) begin
                    cnt_d   = CNT_ONE;
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                ctrl.o_busy = 1'b1;
                if (!rx_s) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_PRE_SAT) state_d = ST_DONE_ERR;
                end else begin
                    n1_d    = cnt_q;
                    cnt_d   = CNT_ONE;
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                ctrl.o_busy = 1'b1;
                if (rx_s) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_PRE_SAT) state_d = ST_DONE_ERR;
                end else begin
                    n2_d    = cnt_q;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                ctrl.o_busy = 1'b1;
                if (pass_w) begin
                    ratio_d = WIDTH'(r_w);
                    state_d = ST_DONE_OK;
                end else begin
                    state_d = ST_DONE_ERR;
                end
            end
            ST_DONE_OK: begin
                ctrl.o_valid = 1'b1;
                cnt_d        = '0;
                state_d      = ST_IDLE;
            end
            ST_DONE_ERR: begin
                ctrl.o_err = 1'b1;
                cnt_d      = '0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ctrl.o_div_ratio = ratio_q;
endmodule

// File: tb/tb_uart_baud_detect.sv
// Directed bench for uart_baud_detect: four instances cover the prescale, short-counter
// and ratio-range configurations; a negedge monitor records every valid/err pulse.
module tb_uart_baud_detect;
    logic clk;
    logic rst_n;
    logic start [4];
    logic rx    [4];

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    uart_baud_detect_if #(.WIDTH(8)) if0 ();
    uart_baud_detect_if #(.WIDTH(8)) if1 ();
    uart_baud_detect_if #(.WIDTH(8)) if2 ();
    uart_baud_detect_if #(.WIDTH(8)) if3 ();

    assign if0.i_start = start[0];
    assign if1.i_start = start[1];
    assign if2.i_start = start[2];
    assign if3.i_start = start[3];

    uart_baud_detect #(.WIDTH(8), .CNT_W(16), .DIV_SHIFT(0), .TOL_SHIFT(3)) u0 (
        .i_ref_clk(clk), .i_rst(rst_n), .i_rx_in(rx[0]), .ctrl(if0));
    uart_baud_detect #(.WIDTH(8), .CNT_W(16), .DIV_SHIFT(3), .TOL_SHIFT(3)) u1 (
        .i_ref_clk(clk), .i_rst(rst_n), .i_rx_in(rx[1]), .ctrl(if1));
    uart_baud_detect #(.WIDTH(8), .CNT_W(8), .DIV_SHIFT(0), .TOL_SHIFT(3)) u2 (
        .i_ref_clk(clk), .i_rst(rst_n), .i_rx_in(rx[2]), .ctrl(if2));
    uart_baud_detect #(.WIDTH(8), .CNT_W(16), .DIV_SHIFT(1), .TOL_SHIFT(3)) u3 (
        .i_ref_clk(clk), .i_rst(rst_n), .i_rx_in(rx[3]), .ctrl(if3));

    logic       vld [4];
    logic       er  [4];
    logic       bsy [4];
    logic [7:0] rat [4];

    assign vld[0] = if0.o_valid;  assign er[0] = if0.o_err;
    assign vld[1] = if1.o_valid;  assign er[1] = if1.o_err;
    assign vld[2] = if2.o_valid;  assign er[2] = if2.o_err;
    assign vld[3] = if3.o_valid;  assign er[3] = if3.o_err;
    assign bsy[0] = if0.o_busy;   assign rat[0] = if0.o_div_ratio;
    assign bsy[1] = if1.o_busy;   assign rat[1] = if1.o_div_ratio;
    assign bsy[2] = if2.o_busy;   assign rat[2] = if2.o_div_ratio;
    assign bsy[3] = if3.o_busy;   assign rat[3] = if3.o_div_ratio;

    int         vcnt   [4];
    int         ecnt   [4];
    int         both   [4];
    int         vcyc   [4];
    logic [7:0] vratio [4];
    logic       vbusy  [4];
    logic       ebusy  [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < 4; i++) begin
            vcnt[i] = 0; ecnt[i] = 0; both[i] = 0; vcyc[i] = 0;
            vratio[i] = '0; vbusy[i] = 1'b0; ebusy[i] = 1'b0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (vld[i] === 1'b1) begin
                vcnt[i]   <= vcnt[i] + 1;
                vratio[i] <= rat[i];
                vbusy[i]  <= bsy[i];
                vcyc[i]   <= cyc;
            end
            if (er[i] === 1'b1) begin
                ecnt[i]  <= ecnt[i] + 1;
                ebusy[i] <= bsy[i];
            end
            if (vld[i] === 1'b1 && er[i] === 1'b1) both[i] <= both[i] + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic pulse_start(input int idx);
        @(posedge clk); #1 start[idx] = 1'b1;
        @(posedge clk); #1 start[idx] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Start bit low for lo cycles, then alternating data bits of 0x55, stop bit high.
    task automatic drive_frame(input int idx, input int lo, input int hi, output int t0);
        @(posedge clk); #1;
        t0 = cyc;
        for (int b = 0; b < 10; b++) begin
            rx[idx] = (b % 2 == 1);
            repeat ((b % 2 == 1) ? hi : lo) @(posedge clk);
            #1;
        end
        rx[idx] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start[i] = 1'b0;
            rx[i]    = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (vld[i] !== 1'b0) begin tests_failed++; $display("FAIL reset_valid[%0d]: got %b exp 0", i, vld[i]); end
            tests_run++;
            if (er[i] !== 1'b0) begin tests_failed++; $display("FAIL reset_err[%0d]: got %b exp 0", i, er[i]); end
            tests_run++;
            if (bsy[i] !== 1'b0) begin tests_failed++; $display("FAIL reset_busy[%0d]: got %b exp 0", i, bsy[i]); end
            tests_run++;
            if (rat[i] !== 8'd0) begin tests_failed++; $display("FAIL reset_ratio[%0d]: got %0d exp 0", i, rat[i]); end
        end
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int v0, e0, t0;
        v0 = vcnt[0]; e0 = ecnt[0];
        pulse_start(0);
        tests_run++;
        if (bsy[0] !== 1'b1) begin tests_failed++; $display("FAIL basic_busy_armed: got %b exp 1", bsy[0]); end
        drive_frame(0, 16, 16, t0);
        tests_run++;
        if (vcnt[0] - v0 !== 1) begin tests_failed++; $display("FAIL basic_valid_count: got %0d exp 1", vcnt[0] - v0); end
        tests_run++;
        if (ecnt[0] - e0 !== 0) begin tests_failed++; $display("FAIL basic_err_count: got %0d exp 0", ecnt[0] - e0); end
        tests_run++;
        if (vratio[0] !== 8'd16) begin tests_failed++; $display("FAIL basic_ratio_at_valid: got %0d exp 16", vratio[0]); end
        tests_run++;
        if (vbusy[0] !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_at_valid: got %b exp 0", vbusy[0]); end
        tests_run++;
        if (vcyc[0] - t0 !== 36) begin tests_failed++; $display("FAIL basic_latency: got %0d exp 36", vcyc[0] - t0); end
        tests_run++;
        if (rat[0] !== 8'd16) begin tests_failed++; $display("FAIL basic_ratio_hold: got %0d exp 16", rat[0]); end
    endtask

    task automatic test_prescale();
        int v0, e0, t0;
        v0 = vcnt[1]; e0 = ecnt[1];
        pulse_start(1);
        drive_frame(1, 64, 64, t0);
        tests_run++;
        if (vcnt[1] - v0 !== 1) begin tests_failed++; $display("FAIL prescale_valid_count: got %0d exp 1", vcnt[1] - v0); end
        tests_run++;
        if (vratio[1] !== 8'd8) begin tests_failed++; $display("FAIL prescale_ratio: got %0d exp 8", vratio[1]); end
        tests_run++;
        if (vcyc[1] - t0 !== 132) begin tests_failed++; $display("FAIL prescale_latency: got %0d exp 132", vcyc[1] - t0); end
        v0 = vcnt[1]; e0 = ecnt[1];
        drive_frame(1, 40, 40, t0);
        tests_run++;
        if (vcnt[1] - v0 !== 0) begin tests_failed++; $display("FAIL unarmed_valid_count: got %0d exp 0", vcnt[1] - v0); end
        tests_run++;
        if (ecnt[1] - e0 !== 0) begin tests_failed++; $display("FAIL unarmed_err_count: got %0d exp 0", ecnt[1] - e0); end
        tests_run++;
        if (rat[1] !== 8'd8) begin tests_failed++; $display("FAIL unarmed_ratio: got %0d exp 8", rat[1]); end
        tests_run++;
        if (bsy[1] !== 1'b0) begin tests_failed++; $display("FAIL unarmed_busy: got %b exp 0", bsy[1]); end
    endtask

    task automatic test_tolerance();
        int v0, e0, t0;
        v0 = vcnt[0]; e0 = ecnt[0];
        pulse_start(0);
        drive_frame(0, 16, 24, t0);
        tests_run++;
        if (ecnt[0] - e0 !== 1) begin tests_failed++; $display("FAIL tol_err_count: got %0d exp 1", ecnt[0] - e0); end
        tests_run++;
        if (vcnt[0] - v0 !== 0) begin tests_failed++; $display("FAIL tol_valid_count: got %0d exp 0", vcnt[0] - v0); end
        tests_run++;
        if (ebusy[0] !== 1'b0) begin tests_failed++; $display("FAIL tol_busy_at_err: got %b exp 0", ebusy[0]); end
        tests_run++;
        if (rat[0] !== 8'd16) begin tests_failed++; $display("FAIL tol_ratio_kept: got %0d exp 16", rat[0]); end
    endtask

    task automatic test_stuck();
        int v0, e0, t0;
        v0 = vcnt[2]; e0 = ecnt[2];
        pulse_start(2);
        rx[2] = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        tests_run++;
        if (ecnt[2] - e0 !== 1) begin tests_failed++; $display("FAIL stuck_err_count: got %0d exp 1", ecnt[2] - e0); end
        tests_run++;
        if (vcnt[2] - v0 !== 0) begin tests_failed++; $display("FAIL stuck_valid_count: got %0d exp 0", vcnt[2] - v0); end
        tests_run++;
        if (bsy[2] !== 1'b0) begin tests_failed++; $display("FAIL stuck_busy: got %b exp 0", bsy[2]); end
        tests_run++;
        if (rat[2] !== 8'd0) begin tests_failed++; $display("FAIL stuck_ratio: got %0d exp 0", rat[2]); end
        rx[2] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        pulse_start(2);
        tests_run++;
        if (bsy[2] !== 1'b1) begin tests_failed++; $display("FAIL stuck_rearm_busy: got %b exp 1", bsy[2]); end
        v0 = vcnt[2];
        drive_frame(2, 16, 16, t0);
        tests_run++;
        if (vcnt[2] - v0 !== 1 || vratio[2] !== 8'd16) begin
            tests_failed++;
            $display("FAIL stuck_recover: got valids=%0d ratio=%0d exp valids=1 ratio=16", vcnt[2] - v0, vratio[2]);
        end
    endtask

    task automatic test_range();
        int v0, e0, t0;
        v0 = vcnt[3]; e0 = ecnt[3];
        pulse_start(3);
        drive_frame(3, 3, 3, t0);
        tests_run++;
        if (ecnt[3] - e0 !== 1) begin tests_failed++; $display("FAIL range_low_err_count: got %0d exp 1", ecnt[3] - e0); end
        tests_run++;
        if (vcnt[3] - v0 !== 0) begin tests_failed++; $display("FAIL range_low_valid_count: got %0d exp 0", vcnt[3] - v0); end
        tests_run++;
        if (rat[3] !== 8'd0) begin tests_failed++; $display("FAIL range_low_ratio: got %0d exp 0", rat[3]); end
        v0 = vcnt[0]; e0 = ecnt[0];
        pulse_start(0);
        drive_frame(0, 600, 600, t0);
        tests_run++;
        if (ecnt[0] - e0 !== 1) begin tests_failed++; $display("FAIL range_high_err_count: got %0d exp 1", ecnt[0] - e0); end
        tests_run++;
        if (vcnt[0] - v0 !== 0) begin tests_failed++; $display("FAIL range_high_valid_count: got %0d exp 0", vcnt[0] - v0); end
        tests_run++;
        if (rat[0] !== 8'd16) begin tests_failed++; $display("FAIL range_high_ratio: got %0d exp 16", rat[0]); end
    endtask

    task automatic test_reset_abort();
        int v0, t0;
        pulse_start(0);
        rx[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        tests_run++;
        if (bsy[0] !== 1'b1) begin tests_failed++; $display("FAIL abort_busy_before: got %b exp 1", bsy[0]); end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (bsy[0] !== 1'b0 || vld[0] !== 1'b0 || er[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_flags: got busy=%b valid=%b err=%b exp all 0", bsy[0], vld[0], er[0]);
        end
        tests_run++;
        if (rat[0] !== 8'd0) begin tests_failed++; $display("FAIL abort_ratio: got %0d exp 0", rat[0]); end
        rx[0] = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (bsy[0] !== 1'b0) begin tests_failed++; $display("FAIL abort_idle_after: got %b exp 0", bsy[0]); end
        v0 = vcnt[0];
        pulse_start(0);
        drive_frame(0, 20, 20, t0);
        tests_run++;
        if (vcnt[0] - v0 !== 1) begin tests_failed++; $display("FAIL abort_valid_count: got %0d exp 1", vcnt[0] - v0); end
        tests_run++;
        if (rat[0] !== 8'd20) begin tests_failed++; $display("FAIL abort_ratio_after: got %0d exp 20", rat[0]); end
        tests_run++;
        if (vcyc[0] - t0 !== 44) begin tests_failed++; $display("FAIL abort_latency: got %0d exp 44", vcyc[0] - t0); end
    endtask

    task automatic test_exclusive();
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (both[i] !== 0) begin tests_failed++; $display("FAIL valid_err_overlap[%0d]: got %0d exp 0", i, both[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_prescale();
        test_tolerance();
        test_stuck();
        test_range();
        test_reset_abort();
        test_exclusive();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
